// File: rtl/id_ex_estagio.sv
`default_nettype none
// ---------------------------------------------------------------------------
// id_ex_estagio : ID/EX pipeline register with load-use hazard detection
// Rev 1.0
// ---------------------------------------------------------------------------
module id_ex_estagio #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [DATA_W-1:0]  id_pc,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic [REG_W-1:0]   id_rd,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_mem_to_reg,
    input  logic               id_alu_src,
    input  logic               id_reg_dst,
    input  logic               id_branch,
    input  logic [ALUOP_W-1:0] id_alu_op,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  ex_pc,
    output logic [DATA_W-1:0]  ex_rs_data,
    output logic [DATA_W-1:0]  ex_rt_data,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [REG_W-1:0]   ex_rs,
    output logic [REG_W-1:0]   ex_rt,
    output logic [REG_W-1:0]   ex_rd,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_mem_to_reg,
    output logic               ex_alu_src,
    output logic               ex_reg_dst,
    output logic               ex_branch,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               pc_write,
    output logic               if_id_write,
    output logic               load_use_stall,
    output logic [15:0]        stall_count
);

    localparam logic [15:0] c_cnt_max = 16'hFFFF;

    logic w_hz;
    logic w_bubble;

    // A load in EX whose destination is read by the valid ID instruction; $0 is exempt.
    assign w_hz = ex_valid & ex_mem_read & id_valid & (ex_rt != '0) &
                  ((ex_rt == id_rs) | (ex_rt == id_rt));

    assign load_use_stall = w_hz & ~flush & ~hold;
    assign pc_write       = ~(hold | load_use_stall);
    assign if_id_write    = ~(hold | load_use_stall);
    assign w_bubble       = flush | load_use_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_pc         <= '0;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm        <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_reg_dst    <= 1'b0;
            ex_branch     <= 1'b0;
            ex_alu_op     <= '0;
            stall_count   <= '0;
        end else if (!hold) begin
            // Bubble zeroes every field; a normal load copies ID as presented.
            ex_valid      <= ~w_bubble & id_valid;
            ex_pc         <= w_bubble ? '0 : id_pc;
            ex_rs_data    <= w_bubble ? '0 : id_rs_data;
            ex_rt_data    <= w_bubble ? '0 : id_rt_data;
            ex_imm        <= w_bubble ? '0 : id_imm;
            ex_rs         <= w_bubble ? '0 : id_rs;
            ex_rt         <= w_bubble ? '0 : id_rt;
            ex_rd         <= w_bubble ? '0 : id_rd;
            ex_reg_write  <= ~w_bubble & id_reg_write;
            ex_mem_read   <= ~w_bubble & id_mem_read;
            ex_mem_write  <= ~w_bubble & id_mem_write;
            ex_mem_to_reg <= ~w_bubble & id_mem_to_reg;
            ex_alu_src    <= ~w_bubble & id_alu_src;
            ex_reg_dst    <= ~w_bubble & id_reg_dst;
            ex_branch     <= ~w_bubble & id_branch;
            ex_alu_op     <= w_bubble ? '0 : id_alu_op;
            if (load_use_stall && (stall_count != c_cnt_max)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire
